// File: rtl/mem_array_ctrl.sv
// mem_array_ctrl: single-port memory with req/ready handshake, byte-enable writes and a fill-value clear sweep
// Ports: clock, reset_n (async active-low); req/write/address/in_data/byte_en describe an access,
// accepted when ready and clear is low; clear starts a sweep writing FILL_VALUE to every word;
// ready/busy decode the registered state; out_data/out_valid carry registered read data;
// err pulses for an accepted access at or beyond DEPTH.
module mem_array_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH = 4096,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    req,
    input  logic                    write,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic                    clear,
    output logic                    ready,
    output logic                    busy,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    output logic                    err
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(DEPTH);
    typedef enum logic {CLEAR, IDLE} state_t;
    state_t state, next_state;
    logic [IW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic in_range, accept, last;
    assign ready = state == IDLE;
    assign busy = state == CLEAR;
    assign idx = address[IW-1:0];
    assign in_range = {1'b0, address} < LIMIT;
    assign accept = req && ready && !clear;
    assign last = cnt == LAST;
    always_comb begin
        next_state = state;
        if (state == CLEAR)
            next_state = last ? IDLE : CLEAR;
        else
            next_state = clear ? CLEAR : IDLE;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAR_ON_RESET ? CLEAR : IDLE;
            cnt <= '0;
            out_data <= '0;
            out_valid <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= next_state;
            cnt <= (state == CLEAR && !last) ? cnt + 1'b1 : '0;
            out_valid <= accept && !write;
            err <= accept && !in_range;
            if (accept && !write)
                out_data <= in_range ? mem[idx] : FILL_VALUE;
        end
    end
    // The array itself is never reset; only the sweep initialises it.
    always_ff @(posedge clock) begin
        if (state == CLEAR)
            mem[cnt] <= FILL_VALUE;
        else if (accept && write && in_range)
            for (int i = 0; i < NB; i++)
                if (byte_en[i])
                    mem[idx][8*i +: 8] <= in_data[8*i +: 8];
    end
endmodule
